// File: rtl/adder_acc_ctrl.sv
// Sequencer for the 8-channel conv3 accumulator adder: issues terms, drives counter, flags sums.
// Optional ACC_CTRL_PERF_EN adds job_cnt/stall_cyc performance counters.
module adder_acc_ctrl #(
    parameter int LAT    = 2,
    parameter int CNT_BW = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic              start_ready,
    output logic              issue,
    output logic [5:0]        issue_idx,
    output logic [CNT_BW-1:0] counter,
    output logic              acc_valid,
    output logic              out_valid,
    output logic              busy,
    output logic              cfg_err
`ifdef ACC_CTRL_PERF_EN
    ,
    output logic [15:0]       job_cnt,
    output logic [15:0]       stall_cyc
`endif
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t     state;
    logic [5:0] n_last;
    logic       accept;
    logic       at_last;

    logic [LAT-1:0] dl_v;
    logic [LAT-1:0] dl_last;
    logic [5:0]     dl_idx [LAT];

    // Index of the final term for a job of the given mode; reserved mode runs as 3 terms.
    function automatic logic [5:0] last_of(input logic [1:0] m);
        case (m)
            2'd1:    last_of = 6'd31;
            2'd2:    last_of = 6'd63;
            default: last_of = 6'd2;
        endcase
    endfunction

    // Jobs are only taken in IDLE or on the final issue cycle, which lets jobs chain with no gap.
    always_comb begin
        at_last     = (state == ISSUE) && (issue_idx == n_last);
        start_ready = (state == IDLE) || at_last;
        accept      = start && start_ready && !rst;
        cfg_err     = accept && (mode == 2'd3);
    end

    // Job FSM: walks issue_idx through the job and reloads on a chained accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            issue     <= 1'b0;
            issue_idx <= 6'd0;
            n_last    <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= ISSUE;
                        issue     <= 1'b1;
                        issue_idx <= 6'd0;
                        n_last    <= last_of(mode);
                    end
                end
                ISSUE: begin
                    if (at_last) begin
                        issue_idx <= 6'd0;
                        if (accept) begin
                            n_last <= last_of(mode);
                        end else begin
                            state <= IDLE;
                            issue <= 1'b0;
                        end
                    end else begin
                        issue_idx <= issue_idx + 6'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    issue <= 1'b0;
                end
            endcase
        end
    end

    // Delay line matching the conv3 latency; idx is zeroed for empty slots so counter reads 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_v    <= '0;
            dl_last <= '0;
            for (int i = 0; i < LAT; i++) begin
                dl_idx[i] <= 6'd0;
            end
        end else begin
            dl_v[0]    <= issue;
            dl_last[0] <= at_last;
            dl_idx[0]  <= issue ? issue_idx : 6'd0;
            for (int i = 1; i < LAT; i++) begin
                dl_v[i]    <= dl_v[i-1];
                dl_last[i] <= dl_last[i-1];
                dl_idx[i]  <= dl_idx[i-1];
            end
        end
    end

    // Sum is complete the cycle after the job's last term reaches the adder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= dl_v[LAT-1] && dl_last[LAT-1];
        end
    end

    // Adder-facing view of the delay line output plus the overall activity flag.
    always_comb begin
        acc_valid = dl_v[LAT-1];
        counter   = {{(CNT_BW-6){1'b0}}, dl_idx[LAT-1]};
        busy      = (state != IDLE) || (|dl_v) || out_valid;
    end

`ifdef ACC_CTRL_PERF_EN
    // Saturating counts of finished jobs and of idle gaps after the first job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            job_cnt   <= 16'd0;
            stall_cyc <= 16'd0;
        end else begin
            if (out_valid && job_cnt != 16'hFFFF) begin
                job_cnt <= job_cnt + 16'd1;
            end
            if (!busy && state == IDLE && job_cnt != 16'd0
                && stall_cyc != 16'hFFFF) begin
                stall_cyc <= stall_cyc + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_adder_acc_ctrl.sv
// Self-checking bench for adder_acc_ctrl: directed jobs plus random starts vs a timeline model.
// The model schedules each accepted job's issue/counter/out_valid cycles directly from its length.
module tb_adder_acc_ctrl;

    localparam int LAT  = 2;
    localparam int MAXC = 2048;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic       start_ready;
    logic       issue;
    logic [5:0] issue_idx;
    logic [6:0] counter;
    logic       acc_valid;
    logic       out_valid;
    logic       busy;
    logic       cfg_err;
`ifdef ACC_CTRL_PERF_EN
    logic [15:0] job_cnt;
    logic [15:0] stall_cyc;
`endif

    adder_acc_ctrl #(.LAT(LAT), .CNT_BW(7)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .start_ready (start_ready),
        .issue       (issue),
        .issue_idx   (issue_idx),
        .counter     (counter),
        .acc_valid   (acc_valid),
        .out_valid   (out_valid),
        .busy        (busy),
        .cfg_err     (cfg_err)
`ifdef ACC_CTRL_PERF_EN
        ,
        .job_cnt     (job_cnt),
        .stall_cyc   (stall_cyc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;
    int c;
    int issue_end;
    int acc;
    int exp_jobs;
    int cfg_seen;

    bit e_issue [MAXC];
    int e_idx   [MAXC];
    int e_cnt   [MAXC];
    bit e_accv  [MAXC];
    bit e_outv  [MAXC];
    bit e_busy  [MAXC];
    int e_outn  [MAXC];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d: got %0d expected %0d", tag, c, obs, exp);
        end
    endtask

    function automatic int n_of(input logic [1:0] m);
        case (m)
            2'd1:    return 32;
            2'd2:    return 64;
            default: return 3;
        endcase
    endfunction

    task automatic clear_from(input int from);
        for (int j = from; j < MAXC; j++) begin
            e_issue[j] = 0; e_idx[j] = 0; e_cnt[j] = 0;
            e_accv[j] = 0; e_outv[j] = 0; e_busy[j] = 0; e_outn[j] = 0;
        end
    endtask

    // Accepted at cycle t with n terms: issues t+1..t+n, terms at adder from t+1+LAT,
    // result flagged at t+1+LAT+n.
    task automatic sched(input int t, input int n);
        for (int k = 0; k < n; k++) begin
            e_issue[t+1+k]   = 1;
            e_idx[t+1+k]     = k;
            e_cnt[t+1+LAT+k] = k;
            e_accv[t+1+LAT+k] = 1;
        end
        e_outv[t+1+LAT+n] = 1;
        e_outn[t+1+LAT+n] = n;
        for (int j = t + 1; j <= t + 1 + LAT + n; j++) e_busy[j] = 1;
        issue_end = t + n;
    endtask

    task automatic step(input bit s, input logic [1:0] m);
        bit rdy;
        bit acc_ok;
        start = s;
        mode  = m;
        #1;
        rdy    = (c >= issue_end);
        acc_ok = s && rdy;
        chk("issue", issue, e_issue[c]);
        chk("issue_idx", issue_idx, e_idx[c]);
        chk("counter", counter, e_cnt[c]);
        chk("acc_valid", acc_valid, e_accv[c]);
        chk("out_valid", out_valid, e_outv[c]);
        chk("busy", busy, e_busy[c]);
        chk("start_ready", start_ready, rdy);
        chk("cfg_err", cfg_err, acc_ok && (m == 2'd3));
        if (e_outv[c]) begin
            chk("lane_sum", acc, e_outn[c]);
            exp_jobs++;
        end
        if (cfg_err === 1'b1) cfg_seen++;
        if (acc_valid === 1'b1) acc = (counter == 0) ? 1 : acc + 1;
        if (acc_ok) sched(c, n_of(m));
        @(posedge clk);
        #1;
        c++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 2'd0);
    endtask

    task automatic do_reset();
        start = 0;
        rst   = 1;
        #1;
        chk("rst_issue", issue, 0);
        chk("rst_counter", counter, 0);
        chk("rst_acc_valid", acc_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start_ready", start_ready, 1);
        clear_from(0);
        issue_end = 0;
        acc = 0;
        exp_jobs = 0;
        @(posedge clk);
        #1;
        rst = 0;
        c++;
    endtask

    initial begin
        bit found;
        tests = 0; fails = 0; c = 0;
        issue_end = 0; acc = 0; exp_jobs = 0; cfg_seen = 0;
        start = 0; mode = 0; rst = 1;
        clear_from(0);
        repeat (2) @(posedge clk);
        #3;
        do_reset();
        idle(3);

        step(1, 2'd0);
        idle(10);

        step(1, 2'd2);
        idle(72);

        step(1, 2'd1);
        for (int i = 0; i < 32; i++) step(1, 2'd0);
        idle(12);

        cfg_seen = 0;
        step(1, 2'd3);
        idle(10);
        chk("cfg_err_pulses", cfg_seen, 1);

        step(1, 2'd1);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (e_accv[c] && e_cnt[c] == 20) found = 1;
            else step(0, 2'd0);
        end
        chk("rst_point_found", found, 1);
        do_reset();
        idle(40);

        step(1, 2'd0);
        idle(10);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)));
        end
        idle(80);

`ifdef ACC_CTRL_PERF_EN
        chk("job_cnt", job_cnt, exp_jobs);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
